// File: rtl/rggen_avalon_if.sv
// Avalon-MM bus bundle shared between a host bridge and an agent.
interface rggen_avalon_if #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
);
    logic                       read;
    logic                       write;
    logic [ADDRESS_WIDTH-1:0]   address;
    logic [BUS_WIDTH/8-1:0]     byteenable;
    logic [BUS_WIDTH-1:0]       writedata;
    logic                       waitrequest;
    logic [BUS_WIDTH-1:0]       readdata;
    logic [1:0]                 response;

    modport host (
        output read, write, address, byteenable, writedata,
        input  waitrequest, readdata, response
    );

    modport agent (
        input  read, write, address, byteenable, writedata,
        output waitrequest, readdata, response
    );
endinterface

// File: rtl/rggen_avalon_host_bridge.sv
// Single-outstanding Avalon-MM host bridge: valid/ready request in,
// one bus transfer out, registered status/read data back on a valid/ready response.
module rggen_avalon_host_bridge #(
    parameter int ADDRESS_WIDTH = 16,
    parameter int BUS_WIDTH     = 32
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic                       i_request_valid,
    output logic                       o_request_ready,
    input  logic                       i_request_write,
    input  logic [ADDRESS_WIDTH-1:0]   i_request_address,
    input  logic [BUS_WIDTH-1:0]       i_request_write_data,
    input  logic [BUS_WIDTH/8-1:0]     i_request_strobe,
    output logic                       o_response_valid,
    input  logic                       i_response_ready,
    output logic [1:0]                 o_response_status,
    output logic [BUS_WIDTH-1:0]       o_response_read_data,
    rggen_avalon_if.host               avalon_if
);
    localparam int                       LSB       = $clog2(BUS_WIDTH / 8);
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK = ADDRESS_WIDTH'((1 << LSB) - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    state_e                     state_q, state_d;
    logic                       read_q, read_d;
    logic                       write_q, write_d;
    logic [ADDRESS_WIDTH-1:0]   address_q, address_d;
    logic [BUS_WIDTH/8-1:0]     byteenable_q, byteenable_d;
    logic [BUS_WIDTH-1:0]       writedata_q, writedata_d;
    logic [1:0]                 status_q, status_d;
    logic [BUS_WIDTH-1:0]       rdata_q, rdata_d;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            read_q       <= 1'b0;
            write_q      <= 1'b0;
            address_q    <= '0;
            byteenable_q <= '0;
            writedata_q  <= '0;
            status_q     <= '0;
            rdata_q      <= '0;
        end else begin
            state_q      <= state_d;
            read_q       <= read_d;
            write_q      <= write_d;
            address_q    <= address_d;
            byteenable_q <= byteenable_d;
            writedata_q  <= writedata_d;
            status_q     <= status_d;
            rdata_q      <= rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        read_d       = read_q;
        write_d      = write_q;
        address_d    = address_q;
        byteenable_d = byteenable_q;
        writedata_d  = writedata_q;
        status_d     = status_q;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (i_request_valid) begin
                    state_d      = BUSY;
                    read_d       = !i_request_write;
                    write_d      = i_request_write;
                    address_d    = i_request_address & ~ADDR_MASK;
                    byteenable_d = i_request_write ? i_request_strobe : '1;
                    writedata_d  = i_request_write ? i_request_write_data : '0;
                end
            end
            BUSY: begin
                // Bus outputs are left untouched until the agent drops waitrequest.
                if (!avalon_if.waitrequest) begin
                    state_d  = RESP;
                    read_d   = 1'b0;
                    write_d  = 1'b0;
                    status_d = avalon_if.response;
                    rdata_d  = read_q ? avalon_if.readdata : '0;
                end
            end
            RESP: begin
                if (i_response_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign o_request_ready      = (state_q == IDLE);
    assign o_response_valid     = (state_q == RESP);
    assign o_response_status    = status_q;
    assign o_response_read_data = rdata_q;

    assign avalon_if.read       = read_q;
    assign avalon_if.write      = write_q;
    assign avalon_if.address    = address_q;
    assign avalon_if.byteenable = byteenable_q;
    assign avalon_if.writedata  = writedata_q;
endmodule

// File: tb/tb_rggen_avalon_host_bridge.sv
// Scoreboard bench for rggen_avalon_host_bridge with a waitrequest-inserting Avalon agent.
module tb_rggen_avalon_host_bridge;
    localparam int AW = 16;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_write = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [BW-1:0] req_wdata = '0;
    logic [3:0]    req_strb = '0;
    logic          req_ready;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [1:0]    rsp_status;
    logic [BW-1:0] rsp_rdata;

    always #5 clk = ~clk;

    rggen_avalon_if #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) bus ();

    rggen_avalon_host_bridge #(.ADDRESS_WIDTH(AW), .BUS_WIDTH(BW)) dut (
        .i_clk                (clk),
        .i_rst_n              (rst_n),
        .i_request_valid      (req_valid),
        .o_request_ready      (req_ready),
        .i_request_write      (req_write),
        .i_request_address    (req_addr),
        .i_request_write_data (req_wdata),
        .i_request_strobe     (req_strb),
        .o_response_valid     (rsp_valid),
        .i_response_ready     (rsp_ready),
        .o_response_status    (rsp_status),
        .o_response_read_data (rsp_rdata),
        .avalon_if            (bus)
    );

    typedef struct {
        logic          write;
        logic [AW-1:0] addr;
        logic [3:0]    be;
        logic [BW-1:0] wd;
        int            cycles;
    } bus_exp_t;

    typedef struct {
        logic [1:0]    status;
        logic [BW-1:0] data;
    } rsp_exp_t;

    bus_exp_t bus_q[$];
    rsp_exp_t rsp_q[$];

    int checks = 0;
    int failures = 0;

    int            cur_waits = 0;
    logic [BW-1:0] cur_rdata = '0;
    logic [1:0]    cur_resp = '0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic finish_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    endtask

    task automatic abort(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=timeout required=event (t=%0t)", name, $time);
        finish_run();
    endtask

    // Agent: stretches each transfer by cur_waits cycles, garbage on readdata while waiting.
    initial begin
        bit active;
        int waited;
        active = 1'b0;
        waited = 0;
        bus.waitrequest = 1'b0;
        bus.readdata = '0;
        bus.response = '0;
        forever begin
            @(posedge clk);
            #1;
            if (bus.read || bus.write) begin
                if (!active) begin
                    active = 1'b1;
                    waited = 0;
                end else begin
                    waited++;
                end
                bus.waitrequest = (waited < cur_waits);
            end else begin
                active = 1'b0;
                bus.waitrequest = 1'($urandom_range(0, 1));
            end
            if (bus.waitrequest) begin
                bus.readdata = $urandom;
                bus.response = 2'($urandom_range(0, 3));
            end else begin
                bus.readdata = cur_rdata;
                bus.response = cur_resp;
            end
        end
    end

    // Bus monitor: command contents, exclusivity, stability and duration of each transfer.
    initial begin
        bit            active;
        int            cnt;
        bus_exp_t      e;
        logic [52:0]   snap;
        active = 1'b0;
        cnt = 0;
        snap = '0;
        e.cycles = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                active = 1'b0;
            end else if (bus.read || bus.write) begin
                chk("rw_exclusive", 64'(bus.read && bus.write), 64'd0);
                if (!active) begin
                    if (bus_q.size() == 0) begin
                        chk("unexpected_transfer", 64'd1, 64'd0);
                        e.cycles = 0;
                    end else begin
                        e = bus_q.pop_front();
                        chk("bus_write", 64'(bus.write), 64'(e.write));
                        chk("bus_address", 64'(bus.address), 64'(e.addr));
                        chk("bus_byteenable", 64'(bus.byteenable), 64'(e.be));
                        chk("bus_writedata", 64'(bus.writedata), 64'(e.wd));
                    end
                    active = 1'b1;
                    cnt = 1;
                    snap = {bus.write, bus.address, bus.byteenable, bus.writedata};
                end else begin
                    cnt++;
                    chk("bus_stable", 64'({bus.write, bus.address, bus.byteenable, bus.writedata}),
                        64'(snap));
                end
            end else if (active) begin
                chk("bus_cycles", 64'(cnt), 64'(e.cycles));
                active = 1'b0;
            end
        end
    end

    // Response monitor: pops the scoreboard on every response handshake.
    initial begin
        rsp_exp_t r;
        forever begin
            @(negedge clk);
            if (rst_n && rsp_valid && rsp_ready) begin
                if (rsp_q.size() == 0) begin
                    chk("unexpected_response", 64'd1, 64'd0);
                end else begin
                    r = rsp_q.pop_front();
                    chk("rsp_status", 64'(rsp_status), 64'(r.status));
                    chk("rsp_data", 64'(rsp_rdata), 64'(r.data));
                end
            end
        end
    end

    task automatic wait_accept();
        bit rdy;
        int n;
        n = 0;
        do begin
            rdy = req_ready;
            @(posedge clk);
            #1;
            n++;
            if (n > 50) abort("request_accept");
        end while (!rdy);
    endtask

    task automatic do_req(input logic wr, input logic [AW-1:0] addr, input logic [BW-1:0] wd,
                          input logic [3:0] strb, input int waits, input logic [BW-1:0] rd,
                          input logic [1:0] resp, input int hold, input bit keep_valid);
        bus_exp_t be;
        rsp_exp_t re;
        int       lat;
        cur_waits = waits;
        cur_rdata = rd;
        cur_resp  = resp;
        be.write  = wr;
        be.addr   = addr & 16'hFFFC;
        be.be     = wr ? strb : 4'hF;
        be.wd     = wr ? wd : '0;
        be.cycles = waits + 1;
        bus_q.push_back(be);
        re.status = resp;
        re.data   = wr ? '0 : rd;
        rsp_q.push_back(re);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wd;
        req_strb  = strb;
        wait_accept();
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid) begin
            chk("ready_low_busy", 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            lat++;
            if (lat > 50) abort("response_valid");
        end
        chk("latency", 64'(lat), 64'(waits + 2));
        if (keep_valid) req_valid = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk);
            #1;
            chk("hold_valid", 64'(rsp_valid), 64'd1);
            chk("hold_req_ready", 64'(req_ready), 64'd0);
            chk("hold_no_rw", 64'({bus.read, bus.write}), 64'd0);
            chk("hold_status", 64'(rsp_status), 64'(re.status));
            chk("hold_data", 64'(rsp_rdata), 64'(re.data));
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        chk("ready_after_resp", 64'(req_ready), 64'd1);
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req_ready"}, 64'(req_ready), 64'd1);
        chk({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        chk({tag, "_rsp_status"}, 64'(rsp_status), 64'd0);
        chk({tag, "_rsp_data"}, 64'(rsp_rdata), 64'd0);
        chk({tag, "_rw"}, 64'({bus.read, bus.write}), 64'd0);
        chk({tag, "_address"}, 64'(bus.address), 64'd0);
        chk({tag, "_byteenable"}, 64'(bus.byteenable), 64'd0);
        chk({tag, "_writedata"}, 64'(bus.writedata), 64'd0);
    endtask

    initial begin
        #200000;
        abort("global_watchdog");
    end

    initial begin
        bus_exp_t      be;
        logic          wr;
        logic [AW-1:0] addr;
        logic [BW-1:0] wd;
        logic [BW-1:0] rd;
        logic [3:0]    strb;
        logic [1:0]    resp;
        int            waits;
        int            hold;

        #1 rst_n = 1'b0;
        #3;
        chk_reset_values("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        do_req(1'b0, 16'h0012, 32'h0, 4'h0, 0, 32'hDEADBEEF, 2'b00, 0, 1'b0);
        do_req(1'b1, 16'h0004, 32'h12345678, 4'b0101, 3, 32'hA5A5A5A5, 2'b00, 0, 1'b0);
        do_req(1'b0, 16'h0100, 32'h0, 4'h0, 1, 32'hCAFEF00D, 2'b11, 5, 1'b1);
        do_req(1'b1, 16'h00FF, 32'hFFFFFFFF, 4'b0000, 0, 32'h55AA55AA, 2'b10, 0, 1'b0);

        // Transfer aborted by reset: bus command is expected, response is not.
        cur_waits = 1000;
        be.write  = 1'b0;
        be.addr   = 16'h0020;
        be.be     = 4'hF;
        be.wd     = '0;
        be.cycles = 0;
        bus_q.push_back(be);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 16'h0022;
        wait_accept();
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("busy_read", 64'({bus.read, bus.waitrequest}), 64'b11);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            chk("no_resp_after_reset", 64'({rsp_valid, bus.read, bus.write}), 64'd0);
        end
        chk("ready_after_reset", 64'(req_ready), 64'd1);

        for (int i = 0; i < 100; i++) begin
            wr    = 1'($urandom_range(0, 1));
            addr  = 16'($urandom);
            wd    = $urandom;
            rd    = $urandom;
            strb  = 4'($urandom);
            resp  = 2'($urandom_range(0, 3));
            waits = $urandom_range(0, 7);
            hold  = $urandom_range(0, 2);
            do_req(wr, addr, wd, strb, waits, rd, resp, hold, 1'b0);
        end

        repeat (3) @(posedge clk);
        #1;
        chk("bus_queue_drained", 64'(bus_q.size()), 64'd0);
        chk("rsp_queue_drained", 64'(rsp_q.size()), 64'd0);
        finish_run();
    end
endmodule
